// File: rtl/ga_pkg.sv
// Shared constants and types for the gate-array interrupt generator.
package ga_pkg;

  // Gate-array command field that carries the interrupt-control bits
  localparam logic [1:0] GA_CMD_MODE    = 2'b10;
  // Bit of the command byte that clears the line divider and a pending INT
  localparam int         GA_INT_CLR_BIT = 4;

  // Classic CPC interrupt cadence
  localparam int GA_INT_DIV_DEF  = 52;
  localparam int GA_VS_DELAY_DEF = 2;

  typedef enum logic {INT_SRC_STD, INT_SRC_PRI} ga_int_src_t;

endpackage

// File: rtl/ga_sync_edge.sv
// CE-gated registered edge detector for one CRTC sync line.
// The previous level is captured only on CE, so edges are seen at the sample rate.
module ga_sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic ce,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic old_reg;

  // Remember the level seen at the previous sample strobe
  always_ff @(posedge CLK) begin
    if (RESET) begin
      old_reg <= 1'b0;
    end else if (ce) begin
      old_reg <= din;
    end
  end

  assign rise = ce & ~old_reg & din;
  assign fall = ce & old_reg & ~din;

endmodule

// File: rtl/ga_int_ctrl.sv
// Gate-array interrupt generator: raises INT every DIV HSYNC falls and
// resynchronises to VSYNC after VS_DELAY lines.
// Optional feature macro: GA_PRI_EN adds a programmable raster interrupt (PRI)
// that replaces the DIV/resync requests while its compare value is non-zero.
module ga_int_ctrl
  import ga_pkg::*;
#(
  parameter int CNT_W    = 6,
  parameter int DIV      = GA_INT_DIV_DEF,
  parameter int VS_DELAY = GA_VS_DELAY_DEF,
  parameter int LINE_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CE_1M,
  input  logic              crtc_hs,
  input  logic              crtc_vs,
  input  logic              INTack,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              pri_we,
  input  logic [LINE_W-1:0] pri_line,
  output logic              INT,
  output logic              int_src,
  output logic [CNT_W-1:0]  line_cnt
);

  localparam logic [CNT_W-1:0] DIV_VAL      = CNT_W'(DIV);
  localparam logic [1:0]       VS_DELAY_VAL = 2'(VS_DELAY);

  // Edge detection: index 0 is HSYNC, index 1 is VSYNC
  logic [1:0] sync_in;
  logic [1:0] edge_rise;
  logic [1:0] edge_fall;
  logic       hs_fall;
  logic       vs_rise;
  logic       unused_edges;

  assign sync_in = {crtc_vs, crtc_hs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      ga_sync_edge u_edge (
        .CLK   (CLK),
        .RESET (RESET),
        .ce    (CE_1M),
        .din   (sync_in[gi]),
        .rise  (edge_rise[gi]),
        .fall  (edge_fall[gi])
      );
    end
  endgenerate

  assign hs_fall      = edge_fall[0];
  assign vs_rise      = edge_rise[1];
  assign unused_edges = edge_rise[0] ^ edge_fall[1];

  // Only the command field and the clear bit of a write matter here
  logic unused_wr;
  assign unused_wr = ^{wr_data[5], wr_data[3:0]};

  // PRI hooks seen by the main next-state logic
  logic pri_active;
  logic pri_hit;

`ifdef GA_PRI_EN
  logic [LINE_W-1:0] pri_cnt_reg, pri_cnt_next, pri_cnt_inc;
  logic [LINE_W-1:0] pri_cmp_reg, pri_cmp_next;

  // Line counter saturates so a late compare value never wraps into a false hit
  assign pri_cnt_inc = (&pri_cnt_reg) ? pri_cnt_reg : pri_cnt_reg + LINE_W'(1);
  assign pri_active  = (pri_cmp_reg != '0);
  assign pri_hit     = hs_fall && pri_active && (pri_cnt_inc == pri_cmp_reg);

  // PRI line counter and compare register next state; VSYNC wins over HSYNC
  always_comb begin
    pri_cnt_next = pri_cnt_reg;
    pri_cmp_next = pri_cmp_reg;
    if (hs_fall) pri_cnt_next = pri_cnt_inc;
    if (vs_rise) pri_cnt_next = '0;
    if (pri_we)  pri_cmp_next = pri_line;
  end

  // PRI state registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pri_cnt_reg <= '0;
      pri_cmp_reg <= '0;
    end else begin
      pri_cnt_reg <= pri_cnt_next;
      pri_cmp_reg <= pri_cmp_next;
    end
  end
`else
  logic unused_pri;
  assign pri_active = 1'b0;
  assign pri_hit    = 1'b0;
  assign unused_pri = pri_we ^ (^pri_line);
`endif

  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_step;
  logic [1:0]       sync_cnt_reg, sync_cnt_next;
  logic             int_reg, int_next;
  logic             std_req;
  ga_int_src_t      src_reg, src_next;

  // Ordered update: ack, then clear write, then HSYNC, then VSYNC; later steps override
  always_comb begin
    cnt_next      = cnt_reg;
    int_next      = int_reg;
    src_next      = src_reg;
    sync_cnt_next = sync_cnt_reg;
    cnt_step      = '0;
    std_req       = 1'b0;

    if (INTack) begin
      int_next             = 1'b0;
      src_next             = INT_SRC_STD;
      cnt_next[CNT_W-1]    = 1'b0;
    end

    if (wr_en && (wr_data[7:6] == GA_CMD_MODE) && wr_data[GA_INT_CLR_BIT]) begin
      cnt_next = '0;
      int_next = 1'b0;
    end

    if (hs_fall) begin
      // Step is based on the registered count, so it overrides ack/clear updates
      cnt_step = cnt_reg + CNT_W'(1);
      if (cnt_step == DIV_VAL) begin
        cnt_step = '0;
        std_req  = 1'b1;
      end
      if (sync_cnt_reg < VS_DELAY_VAL) begin
        sync_cnt_next = sync_cnt_reg + 2'd1;
        if (sync_cnt_next == VS_DELAY_VAL) begin
          // Resync only interrupts when the frame is past the counter midpoint
          if (cnt_step[CNT_W-1]) std_req = 1'b1;
          cnt_step = '0;
        end
      end
      cnt_next = cnt_step;
      if (std_req && !pri_active) begin
        int_next = 1'b1;
        src_next = INT_SRC_STD;
      end
      if (pri_hit) begin
        int_next = 1'b1;
        src_next = INT_SRC_PRI;
      end
    end

    if (vs_rise) sync_cnt_next = '0;
  end

  // Divider, resync and request registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_reg      <= '0;
      sync_cnt_reg <= VS_DELAY_VAL;
      int_reg      <= 1'b0;
      src_reg      <= INT_SRC_STD;
    end else begin
      cnt_reg      <= cnt_next;
      sync_cnt_reg <= sync_cnt_next;
      int_reg      <= int_next;
      src_reg      <= src_next;
    end
  end

  assign INT      = int_reg;
  assign int_src  = src_reg;
  assign line_cnt = cnt_reg;

endmodule

// File: tb/tb_ga_int_ctrl.sv
// Self-checking bench for ga_int_ctrl: vector table, directed sequences and
// randomized stimulus against a behavioural model. PRI checks need GA_PRI_EN.
module tb_ga_int_ctrl;

  localparam int CNT_W    = 6;
  localparam int DIV      = 52;
  localparam int VS_DELAY = 2;
  localparam int LINE_W   = 8;
`ifdef GA_PRI_EN
  localparam bit PRI_EN = 1'b1;
`else
  localparam bit PRI_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              CE_1M = 1'b0;
  logic              crtc_hs = 1'b0;
  logic              crtc_vs = 1'b0;
  logic              INTack = 1'b0;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              pri_we = 1'b0;
  logic [LINE_W-1:0] pri_line = '0;
  logic              INT;
  logic              int_src;
  logic [CNT_W-1:0]  line_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state (plain integers)
  int m_cnt, m_sync, m_int, m_src, m_pri_cnt, m_pri_reg;
  bit m_old_hs, m_old_vs;

  always #5 CLK = ~CLK;

  ga_int_ctrl #(
    .CNT_W(CNT_W), .DIV(DIV), .VS_DELAY(VS_DELAY), .LINE_W(LINE_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CE_1M(CE_1M), .crtc_hs(crtc_hs), .crtc_vs(crtc_vs),
    .INTack(INTack), .wr_en(wr_en), .wr_data(wr_data), .pri_we(pri_we),
    .pri_line(pri_line), .INT(INT), .int_src(int_src), .line_cnt(line_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: apply the rules to the inputs present at this clock edge
  task automatic model_clk();
    int  n_cnt, n_sync, n_int, n_src, n_pri_cnt, n_pri_reg, c, pc;
    bit  hsf, vsr, req, pri_on;
    if (RESET) begin
      m_cnt = 0; m_int = 0; m_src = 0; m_sync = VS_DELAY;
      m_pri_cnt = 0; m_pri_reg = 0; m_old_hs = 0; m_old_vs = 0;
      return;
    end
    hsf = CE_1M && m_old_hs && !crtc_hs;
    vsr = CE_1M && !m_old_vs && crtc_vs;
    n_cnt = m_cnt; n_sync = m_sync; n_int = m_int; n_src = m_src;
    n_pri_cnt = m_pri_cnt; n_pri_reg = m_pri_reg;
    pri_on = PRI_EN && (m_pri_reg != 0);
    if (INTack) begin
      n_int = 0; n_src = 0;
      n_cnt = m_cnt % (1 << (CNT_W - 1));
    end
    if (wr_en && wr_data[7:6] == 2'b10 && wr_data[4]) begin
      n_cnt = 0; n_int = 0;
    end
    if (hsf) begin
      req = 0;
      c = (m_cnt + 1) % (1 << CNT_W);
      if (c == DIV) begin c = 0; req = 1; end
      if (m_sync < VS_DELAY) begin
        n_sync = m_sync + 1;
        if (n_sync == VS_DELAY) begin
          if (c >= (1 << (CNT_W - 1))) req = 1;
          c = 0;
        end
      end
      n_cnt = c;
      pc = (m_pri_cnt == (1 << LINE_W) - 1) ? m_pri_cnt : m_pri_cnt + 1;
      n_pri_cnt = pc;
      if (req && !pri_on) begin n_int = 1; n_src = 0; end
      if (pri_on && pc == m_pri_reg) begin n_int = 1; n_src = 1; end
    end
    if (vsr) begin n_sync = 0; n_pri_cnt = 0; end
    if (PRI_EN && pri_we) n_pri_reg = int'(pri_line);
    if (CE_1M) begin m_old_hs = crtc_hs; m_old_vs = crtc_vs; end
    m_cnt = n_cnt; m_sync = n_sync; m_int = n_int; m_src = n_src;
    m_pri_cnt = n_pri_cnt; m_pri_reg = n_pri_reg;
  endtask

  // One clock: model update at the edge, compare 1 time unit later, drop pulses
  task automatic cyc();
    @(posedge CLK);
    model_clk();
    #1;
    chk("model_INT", int'(INT), m_int);
    chk("model_int_src", int'(int_src), m_src);
    chk("model_line_cnt", int'(line_cnt), m_cnt);
    RESET = 1'b0; INTack = 1'b0; wr_en = 1'b0; pri_we = 1'b0;
  endtask

  // One HSYNC pulse ending in a sampled falling edge
  task automatic line();
    CE_1M = 1'b1; crtc_hs = 1'b1; cyc();
    crtc_hs = 1'b0; cyc();
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) line();
  endtask

  typedef struct {
    logic       rst, ce, hs, vs, ack, wr;
    logic [7:0] wd;
    int         exp_int, exp_cnt;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input int rst, ce, hs, vs, ack, wr, wd, ei, ec);
    vec_t v;
    v.rst = rst[0]; v.ce = ce[0]; v.hs = hs[0]; v.vs = vs[0];
    v.ack = ack[0]; v.wr = wr[0]; v.wd = wd[7:0];
    v.exp_int = ei; v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    //            rst ce hs vs ack wr  wd   INT cnt
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 'h00, 0, 0);  // reset state
    tbl[1]  = mk(0, 1, 1, 0, 0, 0, 'h00, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 'h00, 0, 0);  // fall not sampled without CE
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 'h00, 0, 1);  // sampled fall
    tbl[4]  = mk(0, 1, 1, 0, 0, 0, 'h00, 0, 1);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 'h00, 0, 2);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 'h00, 0, 2);  // level low, no edge
    tbl[7]  = mk(0, 1, 0, 0, 0, 1, 'h80, 0, 2);  // clear bit not set
    tbl[8]  = mk(0, 1, 0, 0, 0, 1, 'hD0, 0, 2);  // wrong command field
    tbl[9]  = mk(0, 1, 0, 0, 0, 1, 'h90, 0, 0);  // clear
    tbl[10] = mk(0, 1, 1, 1, 0, 0, 'h00, 0, 0);  // VSYNC rise
    tbl[11] = mk(0, 1, 0, 1, 0, 0, 'h00, 0, 1);
    tbl[12] = mk(0, 1, 1, 1, 0, 0, 'h00, 0, 1);
    tbl[13] = mk(0, 1, 0, 1, 0, 0, 'h00, 0, 0);  // resync, MSB clear: no INT
    tbl[14] = mk(0, 1, 1, 0, 0, 0, 'h00, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 'h00, 0, 1);
    tbl[16] = mk(0, 1, 1, 0, 0, 0, 'h00, 0, 1);
    tbl[17] = mk(0, 1, 0, 0, 0, 1, 'h90, 0, 2);  // fall overrides coincident clear
    tbl[18] = mk(0, 1, 1, 0, 0, 1, 'h90, 0, 0);
    tbl[19] = mk(0, 1, 1, 0, 1, 0, 'h00, 0, 0);  // ack while idle
    tbl[20] = mk(1, 1, 0, 0, 0, 0, 'h00, 0, 0);  // reset again

    for (int i = 0; i < 21; i++) begin
      RESET = tbl[i].rst; CE_1M = tbl[i].ce; crtc_hs = tbl[i].hs; crtc_vs = tbl[i].vs;
      INTack = tbl[i].ack; wr_en = tbl[i].wr; wr_data = tbl[i].wd;
      cyc();
      chk($sformatf("vec%0d_INT", i), int'(INT), tbl[i].exp_int);
      chk($sformatf("vec%0d_line_cnt", i), int'(line_cnt), tbl[i].exp_cnt);
      chk($sformatf("vec%0d_int_src", i), int'(int_src), 0);
      $display("vec %0d: INT=%0d line_cnt=%0d", i, INT, line_cnt);
    end

    // Free run: INT on the 52nd fall
    lines(51);
    chk("run51_INT", int'(INT), 0);
    chk("run51_line_cnt", int'(line_cnt), 51);
    line();
    chk("run52_INT", int'(INT), 1);
    chk("run52_line_cnt", int'(line_cnt), 0);
    $display("free run: INT=%0d line_cnt=%0d", INT, line_cnt);

    // Hold for 10 clocks, then acknowledge
    for (int i = 0; i < 10; i++) cyc();
    chk("hold_INT", int'(INT), 1);
    INTack = 1'b1; cyc();
    chk("ack_INT", int'(INT), 0);
    lines(51);
    chk("cadence51_INT", int'(INT), 0);
    line();
    chk("cadence52_INT", int'(INT), 1);
    $display("ack cadence: INT=%0d line_cnt=%0d", INT, line_cnt);

    // Clear write at line 30 while INT is pending (further falls absorbed)
    lines(30);
    chk("absorb_INT", int'(INT), 1);
    chk("absorb_line_cnt", int'(line_cnt), 30);
    wr_en = 1'b1; wr_data = 8'h90; cyc();
    chk("clr_INT", int'(INT), 0);
    chk("clr_line_cnt", int'(line_cnt), 0);
    lines(51);
    chk("clr51_INT", int'(INT), 0);
    line();
    chk("clr52_INT", int'(INT), 1);
    INTack = 1'b1; cyc();
    $display("clear write: INT=%0d line_cnt=%0d", INT, line_cnt);

    // Ack clears the counter MSB only
    lines(35);
    INTack = 1'b1; cyc();
    chk("ack_msb_line_cnt", int'(line_cnt), 3);
    lines(37);
    chk("pre_vs_line_cnt", int'(line_cnt), 40);

    // VSYNC at line 40: resync interrupt on the 2nd fall
    crtc_vs = 1'b1; cyc();
    line();
    chk("vs40_fall1_INT", int'(INT), 0);
    chk("vs40_fall1_line_cnt", int'(line_cnt), 41);
    line();
    chk("vs40_fall2_INT", int'(INT), 1);
    chk("vs40_fall2_line_cnt", int'(line_cnt), 0);
    crtc_vs = 1'b0; cyc();
    INTack = 1'b1; cyc();
    $display("vsync at 40: resync INT seen");

    // VSYNC at line 10: resync without interrupt
    lines(10);
    crtc_vs = 1'b1; cyc();
    line();
    chk("vs10_fall1_line_cnt", int'(line_cnt), 11);
    line();
    chk("vs10_fall2_INT", int'(INT), 0);
    chk("vs10_fall2_line_cnt", int'(line_cnt), 0);
    crtc_vs = 1'b0; cyc();
    $display("vsync at 10: INT=%0d line_cnt=%0d", INT, line_cnt);

    // Ack coincident with the 52nd fall: the new request wins
    lines(51);
    crtc_hs = 1'b1; cyc();
    crtc_hs = 1'b0; INTack = 1'b1; cyc();
    chk("ack_coinc_INT", int'(INT), 1);
    chk("ack_coinc_line_cnt", int'(line_cnt), 0);
    INTack = 1'b1; cyc();
    chk("ack_after_INT", int'(INT), 0);
    $display("ack coincident: handled");

`ifdef GA_PRI_EN
    // PRI on line 100: DIV and resync requests suppressed for the frame
    pri_we = 1'b1; pri_line = 8'd100; cyc();
    crtc_vs = 1'b1; cyc();
    crtc_vs = 1'b0; cyc();
    for (int i = 1; i < 100; i++) begin
      line();
      chk($sformatf("pri_quiet%0d_INT", i), int'(INT), 0);
    end
    line();
    chk("pri100_INT", int'(INT), 1);
    chk("pri100_int_src", int'(int_src), 1);
    INTack = 1'b1; cyc();
    chk("pri_ack_INT", int'(INT), 0);
    chk("pri_ack_int_src", int'(int_src), 0);
    pri_we = 1'b1; pri_line = 8'd0; cyc();
    wr_en = 1'b1; wr_data = 8'h90; cyc();
    lines(51);
    chk("pri_off51_INT", int'(INT), 0);
    line();
    chk("pri_off52_INT", int'(INT), 1);
    chk("pri_off52_int_src", int'(int_src), 0);
    INTack = 1'b1; cyc();
    $display("pri: line 100 interrupt and cadence restore checked");
`endif

    // Randomized stimulus against the model
    for (int i = 0; i < 20000; i++) begin
      RESET   = ($urandom_range(0, 2999) == 0);
      CE_1M   = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 2) == 0) crtc_hs = ~crtc_hs;
      if ($urandom_range(0, 149) == 0) crtc_vs = ~crtc_vs;
      INTack  = ($urandom_range(0, 29) == 0);
      wr_en   = ($urandom_range(0, 39) == 0);
      wr_data = ($urandom_range(0, 1) == 1) ? 8'h90 : 8'($urandom);
      pri_we  = ($urandom_range(0, 699) == 0);
      pri_line = ($urandom_range(0, 2) == 0) ? '0 : LINE_W'($urandom_range(1, 60));
      cyc();
    end
    $display("random phase: 20000 cycles applied");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
